// File: rtl/spi_ram_master_ctrl.sv
// Host-side sequencer for the SPI slave + RAM block: turns byte read/write requests into two-frame SPI sequences.
// Optional read-address cache enabled by defining SPI_RAM_ADDR_CACHE_EN.
module spi_ram_master_ctrl #(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned TURN_CYCLES = 1,
    parameter logic [7:0]  DUMMY_BYTE  = 8'h06
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE, START, FLAG, SHIFT, TURN, CAPTURE, HOLD, GAP
    } state_t;

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       second, second_nxt;
    logic       op_we;
    logic [7:0] op_addr, op_wdata;
    logic [7:0] rx_shift;
    logic       accept;
    logic       cache_hit;
    logic       data_rd;
    logic [9:0] frame;
    logic [3:0] bit_idx;
    logic       ss_n_nxt, mosi_nxt, ready_nxt, rd_valid_nxt;
    logic [7:0] rd_data_nxt;

    // second=0 selects the address frame, second=1 the data frame of the current op
    always_comb begin
        if (op_we)
            frame = second ? {2'b01, op_wdata} : {2'b00, op_addr};
        else
            frame = second ? {2'b11, DUMMY_BYTE} : {2'b10, op_addr};
    end

    assign data_rd = !op_we && second;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        second_nxt   = second;
        accept       = 1'b0;
        rd_valid_nxt = 1'b0;
        rd_data_nxt  = rd_data;
        case (state)
            IDLE: begin
                if (req && ready) begin
                    state_nxt  = START;
                    cnt_nxt    = '0;
                    accept     = 1'b1;
                    second_nxt = cache_hit;
                end
            end
            START: state_nxt = FLAG;
            FLAG: begin
                state_nxt = SHIFT;
                cnt_nxt   = '0;
            end
            SHIFT: begin
                if (cnt == 4'd9) begin
                    cnt_nxt = '0;
                    if (data_rd)
                        state_nxt = (TURN_CYCLES == 0) ? CAPTURE : TURN;
                    else
                        state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            CAPTURE: begin
                if (cnt == 4'd7) begin
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HOLD: begin
                state_nxt = GAP;
                cnt_nxt   = '0;
                if (data_rd) begin
                    rd_valid_nxt = 1'b1;
                    rd_data_nxt  = rx_shift;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (second) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt  = START;
                        second_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state they describe
    assign bit_idx = 4'd9 - cnt_nxt;

    always_comb begin
        ss_n_nxt  = (state_nxt == IDLE) || (state_nxt == GAP);
        ready_nxt = (state_nxt == IDLE);
        mosi_nxt  = 1'b0;
        case (state_nxt)
            FLAG:    mosi_nxt = frame[9];
            SHIFT:   mosi_nxt = frame[bit_idx];
            default: mosi_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            second   <= 1'b0;
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rx_shift <= '0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            ready    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            second   <= second_nxt;
            SS_n     <= ss_n_nxt;
            MOSI     <= mosi_nxt;
            ready    <= ready_nxt;
            rd_valid <= rd_valid_nxt;
            rd_data  <= rd_data_nxt;
            if (accept) begin
                op_we    <= we;
                op_addr  <= addr;
                op_wdata <= wdata;
            end
            if (state == CAPTURE)
                rx_shift <= {rx_shift[6:0], MISO};
        end
    end

`ifdef SPI_RAM_ADDR_CACHE_EN
    logic [7:0] last_rd_addr;
    logic       last_rd_vld;

    assign cache_hit = last_rd_vld && !we && (addr == last_rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd_addr <= '0;
            last_rd_vld  <= 1'b0;
        end else if (state == HOLD && data_rd) begin
            last_rd_addr <= op_addr;
            last_rd_vld  <= 1'b1;
        end else if (accept && we && addr == last_rd_addr) begin
            last_rd_vld <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Self-checking bench: behavioural SPI RAM slave decodes MOSI frames and serves MISO; ops checked against a model.
module tb_spi_ram_master_ctrl;
    localparam int G = 2;
    localparam int T = 1;
    localparam logic [7:0] DUMMY = 8'h06;
`ifdef SPI_RAM_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic we = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic ready, rd_valid, SS_n, MOSI;
    logic [7:0] rd_data;
    logic MISO = 1'b0;

    spi_ram_master_ctrl #(.GAP_CYCLES(G), .TURN_CYCLES(T), .DUMMY_BYTE(DUMMY)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: frame = start bit, flag bit, 10-bit word; 11 frames return mem[read addr] MSB first
    typedef struct {
        logic [9:0] word;
        logic       flag;
        bit         fmt_ok;
        int         len;
        int         gap;
    } frame_t;

    frame_t fq[$];
    bit in_frame = 1'b0;
    int k = 0, hi_cnt = 0, gap_b = 0, mosi_idle_err = 0;
    logic [9:0] w = '0;
    logic fl = 1'b0;
    bit fok = 1'b1;
    bit [7:0] smem [256];
    logic [7:0] s_wa = '0, s_ra = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            hi_cnt   = 0;
            MISO     = 1'b0;
        end else if (!SS_n) begin
            if (!in_frame) begin
                in_frame = 1'b1; k = 0; gap_b = hi_cnt; w = '0; fl = 1'b0; fok = 1'b1;
            end
            if (k == 0) fok &= (MOSI === 1'b0);
            else if (k == 1) fl = MOSI;
            else if (k <= 11) w = {w[8:0], MOSI};
            else fok &= (MOSI === 1'b0);
            if (k == 11) begin
                case (w[9:8])
                    2'b00: s_wa = w[7:0];
                    2'b01: smem[s_wa] = w[7:0];
                    2'b10: s_ra = w[7:0];
                    default: ;
                endcase
            end
            if (w[9:8] == 2'b11 && k >= 12 + T && k <= 19 + T)
                MISO = smem[s_ra][19 + T - k];
            else
                MISO = 1'b0;
            k++;
            hi_cnt = 0;
        end else begin
            if (in_frame) begin
                fq.push_back('{word: w, flag: fl, fmt_ok: fok, len: k, gap: gap_b});
                in_frame = 1'b0;
            end
            if (MOSI !== 1'b0) mosi_idle_err++;
            hi_cnt++;
            MISO = 1'b0;
        end
    end

    int rv_cnt = 0, rv_cyc = 0;
    always @(negedge clk) begin
        if (!rst && rd_valid === 1'b1) begin
            rv_cnt++;
            rv_cyc = cyc;
        end
    end

    bit [7:0] exp_mem [256];
    bit c_vld = 1'b0;
    logic [7:0] c_addr = '0;

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    // poke>0: pulse a write request that many cycles into the op; it must be ignored
    task automatic do_op(input bit we_i, input logic [7:0] a, input logic [7:0] d, input int poke);
        bit hit, ok;
        int acc, dur, rc0, nfr, n;
        int exp_dur, exp_rv;
        logic [9:0] exp_w [2];
        int exp_len [2];
        frame_t f;
        wait_ready(ok);
        if (!ok) return;
        hit = CACHE && !we_i && c_vld && (c_addr == a);
        rc0 = rv_cnt;
        req = 1'b1; we = we_i; addr = a; wdata = d;
        @(posedge clk); #1;
        acc = cyc;
        req = 1'b0;
        ok = 1'b0;
        for (n = 1; n < 200; n++) begin
            @(posedge clk); #1;
            if (n == poke) begin
                req = 1'b1; we = 1'b1; addr = 8'($urandom); wdata = 8'($urandom);
            end else if (n == poke + 1) begin
                req = 1'b0;
            end
            if (ready === 1'b1) begin ok = 1'b1; break; end
        end
        req = 1'b0;
        if (!ok) begin chk("op_timeout", 0, 1); fq.delete(); return; end
        dur = cyc - acc;
        if (we_i) begin
            nfr = 2; exp_dur = 2 * (13 + G);
            exp_w[0] = {2'b00, a}; exp_w[1] = {2'b01, d};
            exp_len[0] = 13; exp_len[1] = 13;
            exp_rv = 0;
        end else if (hit) begin
            nfr = 1; exp_dur = 13 + T + 8 + G;
            exp_w[0] = {2'b11, DUMMY}; exp_len[0] = 13 + T + 8;
            exp_w[1] = '0; exp_len[1] = 0;
            exp_rv = 13 + T + 8;
        end else begin
            nfr = 2; exp_dur = 2 * (13 + G) + T + 8;
            exp_w[0] = {2'b10, a}; exp_w[1] = {2'b11, DUMMY};
            exp_len[0] = 13; exp_len[1] = 13 + T + 8;
            exp_rv = (13 + G) + (13 + T + 8);
        end
        chk("op_duration", dur, exp_dur);
        chk("frame_count", fq.size(), nfr);
        if (fq.size() == nfr) begin
            for (int i = 0; i < nfr; i++) begin
                f = fq.pop_front();
                chk("frame_word", {22'd0, f.word}, {22'd0, exp_w[i]});
                chk("frame_format", {30'd0, f.fmt_ok, f.flag === f.word[9]}, 32'd3);
                chk("frame_ss_low", f.len, exp_len[i]);
                if (i == 1) chk("frame_gap", f.gap, G);
            end
        end else begin
            fq.delete();
        end
        if (we_i) begin
            chk("wr_no_rd_valid", rv_cnt - rc0, 0);
            exp_mem[a] = d;
            if (c_addr == a) c_vld = 1'b0;
        end else begin
            chk("rd_valid_pulses", rv_cnt - rc0, 1);
            chk("rd_valid_time", rv_cyc - acc, exp_rv);
            chk("rd_data", {24'd0, rd_data}, {24'd0, exp_mem[a]});
            c_vld = 1'b1; c_addr = a;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, prev_r;
        int acc [3];
        int na;
        logic [7:0] bb_a [3];
        logic [7:0] bb_d [3];
        logic [7:0] ra, rdv;
        frame_t f;

        repeat (3) @(negedge clk);
        chk("rst_SS_n", SS_n, 1);
        chk("rst_MOSI", MOSI, 0);
        chk("rst_ready", ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // reset in the middle of a write frame
        wait_ready(ok);
        req = 1'b1; we = 1'b1; addr = 8'h55; wdata = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("midframe_SS_n_low", SS_n, 0);
        rst = 1'b1;
        #1;
        chk("abort_SS_n", SS_n, 1);
        chk("abort_MOSI", MOSI, 0);
        chk("abort_ready", ready, 1);
        chk("abort_rd_valid", rd_valid, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        fq.delete();
        c_vld = 1'b0;
        do_op(1'b1, 8'h55, 8'h77, 0);

        do_op(1'b1, 8'h3C, 8'hA5, 0);
        do_op(1'b0, 8'h3C, 8'h00, 0);

        // request during a busy read is dropped
        do_op(1'b0, 8'h55, 8'h00, 10);
        chk("busy_no_extra_frames", fq.size(), 0);

        // req held over three writes
        bb_a[0] = 8'h81; bb_a[1] = 8'h82; bb_a[2] = 8'h83;
        bb_d[0] = 8'h11; bb_d[1] = 8'hE2; bb_d[2] = 8'h5B;
        wait_ready(ok);
        req = 1'b1; we = 1'b1; addr = bb_a[0]; wdata = bb_d[0];
        prev_r = 1'b1; na = 0; ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (prev_r && ready === 1'b0) begin
                acc[na] = cyc;
                na++;
                if (na < 3) begin addr = bb_a[na]; wdata = bb_d[na]; end
                else req = 1'b0;
            end
            prev_r = ready;
            if (na == 3 && ready === 1'b1) begin ok = 1'b1; break; end
        end
        req = 1'b0;
        chk("b2b_accepts", na, 3);
        chk("b2b_done", ok, 1);
        if (na == 3) begin
            chk("b2b_spacing_1", acc[1] - acc[0], 2 * (13 + G) + 1);
            chk("b2b_spacing_2", acc[2] - acc[1], 2 * (13 + G) + 1);
        end
        chk("b2b_frames", fq.size(), 6);
        if (fq.size() == 6) begin
            for (int i = 0; i < 3; i++) begin
                f = fq.pop_front();
                chk("b2b_addr_frame", {22'd0, f.word}, {24'd0, bb_a[i]});
                f = fq.pop_front();
                chk("b2b_data_frame", {22'd0, f.word}, {22'd0, 2'b01, bb_d[i]});
            end
        end
        fq.delete();
        for (int i = 0; i < 3; i++) begin
            exp_mem[bb_a[i]] = bb_d[i];
            if (c_addr == bb_a[i]) c_vld = 1'b0;
        end
        for (int i = 0; i < 3; i++) do_op(1'b0, bb_a[i], 8'h00, 0);

        // repeated read of one address, then with an intervening write
        do_op(1'b1, 8'h10, 8'hC3, 0);
        do_op(1'b0, 8'h10, 8'h00, 0);
        do_op(1'b0, 8'h10, 8'h00, 0);
        do_op(1'b1, 8'h10, 8'h3E, 0);
        do_op(1'b0, 8'h10, 8'h00, 0);

        for (int i = 0; i < 10; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rdv = 8'($urandom);
            do_op(1'b1, ra, rdv, 0);
            do_op(1'b0, ra, 8'h00, 0);
        end

        chk("mosi_zero_when_idle", mosi_idle_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
